alu_decode_stage: RTL and testbench
===================================

Name: alu_decode_stage

Overview:
- Decode stage directly upstream of the ALU in the RV32I integer pipeline.
- Accepts fetched instructions over a valid/ready handshake and reads rs1/rs2 from the register file.
- Produces the registered operand pair, the 5-bit ALU select (alu_pkg op enum), destination register and write enable.
- Holds one instruction in an output pipeline register with backpressure and flush.

Parameters:
WIDTH, 32, datapath width; must be >= 32; immediates sign-extended to WIDTH.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_valid  in  1  fetch presents an instruction
if_ready  out  1  stage accepts the instruction this cycle
if_instr  in  32  instruction word
if_pc  in  WIDTH  PC of if_instr
rf_rs1_addr  out  5  register-file read address 1, combinational from if_instr[19:15]
rf_rs2_addr  out  5  register-file read address 2, combinational from if_instr[24:20]
rf_rs1_data  in  WIDTH  combinational read data 1 (x0 reads 0)
rf_rs2_data  in  WIDTH  combinational read data 2
flush  in  1  kill held and incoming instruction (branch redirect)
ex_valid  out  1  output register holds a valid instruction
ex_ready  in  1  ALU/execute consumes this cycle
ex_in1  out  WIDTH  ALU operand 1
ex_in2  out  WIDTH  ALU operand 2
ex_sel  out  5  ALU select, alu_pkg op enum
ex_rd  out  5  destination register
ex_rd_we  out  1  writeback enable
ex_pc  out  WIDTH  PC of held instruction
ex_illegal  out  1  held instruction is unsupported/illegal

Behaviour:
- Clocking/reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: all ex_* outputs 0. ex_sel = add.
- Handshake:
  - if_ready = !ex_valid || ex_ready (combinational; no dependence on if_valid).
  - Capture when if_valid && if_ready && !flush; the output register loads on the next clk edge, giving 1-cycle latency.
  - Held when ex_valid && !ex_ready: all ex_* outputs stable.
  - If ex_valid && ex_ready && !(if_valid && if_ready): ex_valid goes to 0.
  - Back-to-back: one instruction per cycle when ex_ready is held high.
- Flush: has priority over capture. ex_valid goes to 0 next cycle and the incoming instruction is dropped. Data fields may keep stale values. Flush during rst is irrelevant (rst wins).
- Decode by opcode, and funct3/funct7:
  - OP (0110011): in1=rs1, in2=rs2.
    - funct7=0000000: add/sll/slt/sltu/xor/srl/or/and.
    - funct7=0100000: sub (f3=000) or sra (f3=101).
    - Any other funct7/funct3 pairing is illegal.
  - OP-IMM (0010011): in1=rs1, in2=sign-extended instr[31:20].
    - Sel = addi/slti/sltiu/xori/ori/andi.
    - Shifts: in2 = zero-extended shamt instr[24:20].
    - f3=001 requires funct7=0000000 (slli).
    - f3=101 with funct7=0000000 gives srli; with 0100000 gives srai; any other funct7 is illegal.
  - LUI (0110111): sel=lui, in1=0, in2={instr[31:12],12'b0} sign-extended.
  - AUIPC (0010111): sel=auipc, in1=if_pc, in2 = U-immediate as for LUI.
  - Any other opcode is illegal.
- Illegal instructions: ex_illegal=1, ex_sel=add, ex_rd_we=0, operands 0. The instruction still flows through the handshake.
- ex_rd = instr[11:7]. ex_rd_we = legal && rd != 0.
- Register-file data is sampled in the capture cycle only. Hazard forwarding is out of scope for this block.

Decomposition:
- alu_pkg: op enum (already shared with the ALU), opcode constants OPC_OP/OPC_OP_IMM/OPC_LUI/OPC_AUIPC, funct7 constants F7_BASE/F7_ALT.
- Sub-module rv_alu_decoder: purely combinational; instr, pc, rs1/rs2 data in; sel, in1, in2, rd, rd_we, illegal out.
- Top module alu_decode_stage: handshake plus output register.

Test Plan:
- Reset:
  - Stimulus: rst high 2 cycles, if_valid=1.
  - Response: ex_valid=0, ex_sel=add, all ex_* 0; if_ready=1.
- Register-register ADD:
  - Stimulus: if_instr=0x002081B3 (add x3,x1,x2), rs1_data=5, rs2_data=7, ex_ready=1.
  - Response: next cycle ex_valid=1, sel=add, in1=5, in2=7, rd=3, rd_we=1.
- Immediate decodes:
  - 0xFFF00093 (addi x1,x0,-1): in2=0xFFFFFFFF, sel=addi.
  - 0x40335293 (srai x5,x6,3): sel=srai, in2=3.
  - 0x123453B7 (lui x7,0x12345) with pc=0x100: in1=0, in2=0x12345000.
- Illegal instructions:
  - 0x00000000: ex_illegal=1, rd_we=0, sel=add.
  - 0x42335293 (funct7=0100001 shift): ex_illegal=1.
- Backpressure:
  - Stimulus: ex_ready=0 for 3 cycles with a second instruction pending.
  - Response: if_ready=0, outputs stable.
  - Then ex_ready=1: second instruction appears the next cycle; no instruction is lost or duplicated.
- Flush:
  - Stimulus: flush=1 with ex_valid=1 and if_valid=1.
  - Response: next cycle ex_valid=0 and the incoming instruction never appears at the output.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU select encoding and RV32I decode constants.
// Imported by the decode stage, its decoder and the ALU.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_SLL   = 5'd2,
        OP_SLT   = 5'd3,
        OP_SLTU  = 5'd4,
        OP_XOR   = 5'd5,
        OP_SRL   = 5'd6,
        OP_SRA   = 5'd7,
        OP_OR    = 5'd8,
        OP_AND   = 5'd9,
        OP_ADDI  = 5'd10,
        OP_SLTI  = 5'd11,
        OP_SLTIU = 5'd12,
        OP_XORI  = 5'd13,
        OP_ORI   = 5'd14,
        OP_ANDI  = 5'd15,
        OP_SLLI  = 5'd16,
        OP_SRLI  = 5'd17,
        OP_SRAI  = 5'd18,
        OP_LUI   = 5'd19,
        OP_AUIPC = 5'd20
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/rv_alu_decoder.sv
// Combinational RV32I ALU-class decoder: select, operands, rd.
// Illegal words decode to a harmless add of zeros.
module rv_alu_decoder
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    output alu_op_e          sel,
    output logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] in2,
    output logic [4:0]       rd,
    output logic             rd_we,
    output logic             illegal
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    logic signed [11:0] imm_i;
    logic signed [31:0] imm_u;
    logic [WIDTH-1:0]   shamt;

    alu_op_e          sel_raw;
    logic [WIDTH-1:0] in1_raw;
    logic [WIDTH-1:0] in2_raw;
    logic             legal;

    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = instr[31:20];
    assign imm_u = {instr[31:12], 12'b0};
    assign shamt = WIDTH'(instr[24:20]);

    always_comb begin
        sel_raw = OP_ADD;
        in1_raw = '0;
        in2_raw = '0;
        legal   = 1'b0;
        unique case (1'b1)
            (opc == OPC_OP): begin
                in1_raw = rs1_data;
                in2_raw = rs2_data;
                if (f7 == F7_BASE) begin
                    legal = 1'b1;
                    case (f3)
                        3'b000:  sel_raw = OP_ADD;
                        3'b001:  sel_raw = OP_SLL;
                        3'b010:  sel_raw = OP_SLT;
                        3'b011:  sel_raw = OP_SLTU;
                        3'b100:  sel_raw = OP_XOR;
                        3'b101:  sel_raw = OP_SRL;
                        3'b110:  sel_raw = OP_OR;
                        default: sel_raw = OP_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    legal   = 1'b1;
                    sel_raw = OP_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    legal   = 1'b1;
                    sel_raw = OP_SRA;
                end
            end
            (opc == OPC_OP_IMM): begin
                in1_raw = rs1_data;
                in2_raw = WIDTH'(imm_i);
                legal   = 1'b1;
                case (f3)
                    3'b000: sel_raw = OP_ADDI;
                    3'b010: sel_raw = OP_SLTI;
                    3'b011: sel_raw = OP_SLTIU;
                    3'b100: sel_raw = OP_XORI;
                    3'b110: sel_raw = OP_ORI;
                    3'b111: sel_raw = OP_ANDI;
                    3'b001: begin
                        sel_raw = OP_SLLI;
                        in2_raw = shamt;
                        legal   = (f7 == F7_BASE);
                    end
                    default: begin
                        in2_raw = shamt;
                        if (f7 == F7_BASE) begin
                            sel_raw = OP_SRLI;
                        end else if (f7 == F7_ALT) begin
                            sel_raw = OP_SRAI;
                        end else begin
                            legal = 1'b0;
                        end
                    end
                endcase
            end
            (opc == OPC_LUI): begin
                legal   = 1'b1;
                sel_raw = OP_LUI;
                in2_raw = WIDTH'(imm_u);
            end
            (opc == OPC_AUIPC): begin
                legal   = 1'b1;
                sel_raw = OP_AUIPC;
                in1_raw = pc;
                in2_raw = WIDTH'(imm_u);
            end
            default: legal = 1'b0;
        endcase
    end

    assign sel     = legal ? sel_raw : OP_ADD;
    assign in1     = legal ? in1_raw : '0;
    assign in2     = legal ? in2_raw : '0;
    assign rd      = instr[11:7];
    assign rd_we   = legal && (rd != 5'd0);
    assign illegal = !legal;

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage feeding the ALU: valid/ready capture into a
// single output register with backpressure and flush.
module alu_decode_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_instr,
    input  logic [WIDTH-1:0] if_pc,
    output logic [4:0]       rf_rs1_addr,
    output logic [4:0]       rf_rs2_addr,
    input  logic [WIDTH-1:0] rf_rs1_data,
    input  logic [WIDTH-1:0] rf_rs2_data,
    input  logic             flush,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [WIDTH-1:0] ex_in1,
    output logic [WIDTH-1:0] ex_in2,
    output logic [4:0]       ex_sel,
    output logic [4:0]       ex_rd,
    output logic             ex_rd_we,
    output logic [WIDTH-1:0] ex_pc,
    output logic             ex_illegal
);

    alu_op_e          dec_sel;
    logic [WIDTH-1:0] dec_in1;
    logic [WIDTH-1:0] dec_in2;
    logic [4:0]       dec_rd;
    logic             dec_rd_we;
    logic             dec_illegal;
    logic             capture;

    assign rf_rs1_addr = if_instr[19:15];
    assign rf_rs2_addr = if_instr[24:20];

    assign if_ready = !ex_valid || ex_ready;
    assign capture  = if_valid && if_ready && !flush;

    rv_alu_decoder #(
        .WIDTH (WIDTH)
    ) u_dec (
        .instr    (if_instr),
        .pc       (if_pc),
        .rs1_data (rf_rs1_data),
        .rs2_data (rf_rs2_data),
        .sel      (dec_sel),
        .in1      (dec_in1),
        .in2      (dec_in2),
        .rd       (dec_rd),
        .rd_we    (dec_rd_we),
        .illegal  (dec_illegal)
    );

    // Payload only moves on capture; flush just drops the valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_in1     <= '0;
            ex_in2     <= '0;
            ex_sel     <= OP_ADD;
            ex_rd      <= '0;
            ex_rd_we   <= 1'b0;
            ex_pc      <= '0;
            ex_illegal <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (capture) begin
            ex_valid   <= 1'b1;
            ex_in1     <= dec_in1;
            ex_in2     <= dec_in2;
            ex_sel     <= dec_sel;
            ex_rd      <= dec_rd;
            ex_rd_we   <= dec_rd_we;
            ex_pc      <= if_pc;
            ex_illegal <= dec_illegal;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Randomized bench for alu_decode_stage against a reference
// model of the decode rules and the one-entry handshake.
module tb_alu_decode_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  rf_rs1_addr;
    logic [4:0]  rf_rs2_addr;
    logic [31:0] rf_rs1_data;
    logic [31:0] rf_rs2_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_in1;
    logic [31:0] ex_in2;
    logic [4:0]  ex_sel;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic [31:0] ex_pc;
    logic        ex_illegal;

    logic [31:0] regs [32];

    typedef struct {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  sel;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    int   nchk = 0;
    int   nerr = 0;
    logic mv;
    exp_t mo;

    always #5 clk = ~clk;

    assign rf_rs1_data = regs[rf_rs1_addr];
    assign rf_rs2_data = regs[rf_rs2_addr];

    alu_decode_stage #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .rf_rs1_addr (rf_rs1_addr),
        .rf_rs2_addr (rf_rs2_addr),
        .rf_rs1_data (rf_rs1_data),
        .rf_rs2_data (rf_rs2_data),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_in1      (ex_in1),
        .ex_in2      (ex_in2),
        .ex_sel      (ex_sel),
        .ex_rd       (ex_rd),
        .ex_rd_we    (ex_rd_we),
        .ex_pc       (ex_pc),
        .ex_illegal  (ex_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] i,
                                   input logic [31:0] pc);
        alu_op_e reg_tab [8] = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU,
                                 OP_XOR, OP_SRL, OP_OR, OP_AND};
        alu_op_e imm_tab [8] = '{OP_ADDI, OP_SLLI, OP_SLTI, OP_SLTIU,
                                 OP_XORI, OP_SRLI, OP_ORI, OP_ANDI};
        exp_t e;
        int opc = int'(i & 32'h7f);
        int f3  = int'((i >> 12) & 7);
        int f7  = int'(i >> 25);
        int a1  = int'((i >> 15) & 31);
        int a2  = int'((i >> 20) & 31);
        bit ok  = 0;
        e.sel = OP_ADD;
        e.in1 = 0;
        e.in2 = 0;
        if (opc == 'h33) begin
            e.in1 = regs[a1];
            e.in2 = regs[a2];
            if (f7 == 0) begin
                ok = 1;
                e.sel = reg_tab[f3];
            end else if (f7 == 'h20 && (f3 == 0 || f3 == 5)) begin
                ok = 1;
                e.sel = (f3 == 0) ? OP_SUB : OP_SRA;
            end
        end else if (opc == 'h13) begin
            e.in1 = regs[a1];
            e.sel = imm_tab[f3];
            if (f3 == 1) begin
                ok = (f7 == 0);
                e.in2 = a2;
            end else if (f3 == 5) begin
                ok = (f7 == 0 || f7 == 'h20);
                e.in2 = a2;
                if (f7 == 'h20) e.sel = OP_SRAI;
            end else begin
                ok = 1;
                e.in2 = int'(i) >>> 20;
            end
        end else if (opc == 'h37 || opc == 'h17) begin
            ok = 1;
            e.sel = (opc == 'h37) ? OP_LUI : OP_AUIPC;
            e.in1 = (opc == 'h37) ? 0 : pc;
            e.in2 = i & 32'hffff_f000;
        end
        if (!ok) begin
            e.sel = OP_ADD;
            e.in1 = 0;
            e.in2 = 0;
        end
        e.rd  = 5'((i >> 7) & 31);
        e.we  = ok && e.rd != 0;
        e.ill = !ok;
        e.pc  = pc;
        return e;
    endfunction

    task automatic compare();
        chk("if_ready", 32'(if_ready), 32'(!mv || ex_ready));
        chk("rs1_addr", 32'(rf_rs1_addr), 32'(if_instr[19:15]));
        chk("rs2_addr", 32'(rf_rs2_addr), 32'(if_instr[24:20]));
        chk("ex_valid", 32'(ex_valid), 32'(mv));
        if (mv) begin
            chk("ex_in1", ex_in1, mo.in1);
            chk("ex_in2", ex_in2, mo.in2);
            chk("ex_sel", 32'(ex_sel), 32'(mo.sel));
            chk("ex_rd", 32'(ex_rd), 32'(mo.rd));
            chk("ex_rd_we", 32'(ex_rd_we), 32'(mo.we));
            chk("ex_illegal", 32'(ex_illegal), 32'(mo.ill));
            chk("ex_pc", ex_pc, mo.pc);
        end
    endtask

    task automatic cyc(input logic v, input logic [31:0] ins,
                       input logic [31:0] p, input logic rdy,
                       input logic fl);
        logic acc;
        if_valid = v;
        if_instr = ins;
        if_pc    = p;
        ex_ready = rdy;
        flush    = fl;
        @(negedge clk);
        compare();
        acc = v && (!mv || rdy);
        if (fl) begin
            mv = 0;
        end else if (acc) begin
            mv = 1;
            mo = model(ins, p);
        end else if (rdy) begin
            mv = 0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i = $urandom;
        logic [6:0]  f7;
        int k = $urandom_range(0, 5);
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'($urandom);
            default: f7 = 7'h00;
        endcase
        case (k)
            0: i[6:0] = 7'h33;
            1: i[6:0] = 7'h13;
            2: i[6:0] = 7'h37;
            3: i[6:0] = 7'h17;
            4: i[6:0] = 7'($urandom);
            default: begin
                i[6:0]   = 7'h13;
                i[14:12] = $urandom_range(0, 1) ? 3'd1 : 3'd5;
            end
        endcase
        if (k == 0 || k == 1 || k == 5) i[31:25] = f7;
        return i;
    endfunction

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = (r == 0) ? 0 : $urandom;
        regs[1] = 5;
        regs[2] = 7;
        regs[6] = 32'h8000_0010;
        mv = 0;
        rst = 1;
        if_valid = 1;
        if_instr = 32'h002081B3;
        if_pc = 32'h40;
        ex_ready = 0;
        flush = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_sel", 32'(ex_sel), 32'(OP_ADD));
        chk("rst_in1", ex_in1, 0);
        chk("rst_in2", ex_in2, 0);
        chk("rst_rd", 32'({ex_rd, ex_rd_we, ex_illegal}), 0);
        chk("rst_pc", ex_pc, 0);
        chk("rst_if_ready", 32'(if_ready), 1);
        @(posedge clk);
        #1;
        rst = 0;

        cyc(1, 32'h002081B3, 32'h100, 1, 0);
        chk("add_sel", 32'(ex_sel), 32'(OP_ADD));
        chk("add_in1", ex_in1, 5);
        chk("add_in2", ex_in2, 7);
        chk("add_rd", 32'({ex_rd, ex_rd_we}), {5'd3, 1'b1});
        cyc(1, 32'hFFF00093, 32'h104, 1, 0);
        chk("addi_in2", ex_in2, 32'hFFFF_FFFF);
        chk("addi_sel", 32'(ex_sel), 32'(OP_ADDI));
        cyc(1, 32'h40335293, 32'h108, 1, 0);
        chk("srai_sel", 32'(ex_sel), 32'(OP_SRAI));
        chk("srai_in2", ex_in2, 3);
        cyc(1, 32'h123453B7, 32'h100, 1, 0);
        chk("lui_in1", ex_in1, 0);
        chk("lui_in2", ex_in2, 32'h1234_5000);
        cyc(1, 32'h00000000, 32'h110, 1, 0);
        chk("ill0", 32'({ex_illegal, ex_rd_we}), 32'b10);
        chk("ill0_sel", 32'(ex_sel), 32'(OP_ADD));
        cyc(1, 32'h42335293, 32'h114, 1, 0);
        chk("ill_shift", 32'(ex_illegal), 1);

        // Backpressure: A held for three cycles while B waits.
        cyc(1, 32'h002081B3, 32'h200, 1, 0);
        for (int n = 0; n < 3; n++) begin
            cyc(1, 32'h40335293, 32'h204, 0, 0);
            chk("bp_pc", ex_pc, 32'h200);
        end
        cyc(1, 32'h40335293, 32'h204, 1, 0);
        chk("bp_next_pc", ex_pc, 32'h204);
        cyc(0, 32'h0, 32'h0, 1, 0);

        // Flush with a valid entry and a valid incoming word.
        cyc(1, 32'hFFF00093, 32'h300, 1, 0);
        cyc(1, 32'h123453B7, 32'h304, 1, 1);
        chk("flush_valid", 32'(ex_valid), 0);
        for (int n = 0; n < 3; n++) cyc(0, 32'h0, 32'h0, 1, 0);

        for (int n = 0; n < 3000; n++) begin
            regs[$urandom_range(1, 31)] = $urandom;
            cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
